// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: operating modes and ping-pong direction.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_STEP_UP   = 2'b01,
        MODE_STEP_DOWN = 2'b10,
        MODE_PING_PONG = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts enabled cycles and strobes tick on the cycle the count expires.
module tick_divider #(
    parameter int unsigned DIV_MAX = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(64'(DIV_MAX) + 64'd1);
    localparam logic [CW-1:0] LAST = CW'(DIV_MAX - 1);

    logic [CW-1:0] cnt;

    // tick is an expiry strobe in the current cycle so the caller can act on the same edge
    assign tick = !rst && !clr && en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// One-hot LED channel sequencer with direct select, prescaled up/down/ping-pong
// stepping, synchronous load and registered tick/wrap pulses.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int unsigned DIV_MAX = 50_000_000,
    parameter int          IDX_W   = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] sel,
    input  logic             load,
    input  logic             en,
    output logic [N_CH-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             led,
    output logic             tick,
    output logic             wrap
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

    mode_t            mode_e;
    dir_t             dir, dir_n;
    logic [IDX_W-1:0] idx_n;
    logic [IDX_W-1:0] sel_c;
    logic             tick_n, wrap_n;
    logic             step;

    assign mode_e = mode_t'(mode);

    // Non power-of-two channel counts leave unused sel codes; pin them to the top channel
    assign sel_c = (int'(sel) > N_CH - 1) ? LAST : sel;

    // The prescaler stays cleared in DIRECT so stepping restarts a full period later
    tick_divider #(
        .DIV_MAX(DIV_MAX)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .clr (load || (mode_e == MODE_DIRECT)),
        .en  (en && (mode_e != MODE_DIRECT)),
        .tick(step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            dir  <= DIR_UP;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            idx  <= idx_n;
            dir  <= dir_n;
            tick <= tick_n;
            wrap <= wrap_n;
        end
    end

    always_comb begin
        idx_n  = idx;
        dir_n  = dir;
        tick_n = 1'b0;
        wrap_n = 1'b0;
        if (load) begin
            idx_n = sel_c;
            dir_n = DIR_UP;
        end else if (mode_e == MODE_DIRECT) begin
            idx_n = sel_c;
        end else if (step) begin
            tick_n = 1'b1;
            unique case (mode_e)
                MODE_STEP_UP: begin
                    if (idx == LAST) begin
                        idx_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
                MODE_STEP_DOWN: begin
                    if (idx == '0) begin
                        idx_n  = LAST;
                        wrap_n = 1'b1;
                    end else begin
                        idx_n = idx - IDX_W'(1);
                    end
                end
                // Ping-pong reverses at the ends instead of jumping across
                MODE_PING_PONG: begin
                    if (dir == DIR_UP) begin
                        if (idx == LAST) begin
                            idx_n  = LAST - IDX_W'(1);
                            dir_n  = DIR_DOWN;
                            wrap_n = 1'b1;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        if (idx == '0) begin
                            idx_n  = IDX_W'(1);
                            dir_n  = DIR_UP;
                            wrap_n = 1'b1;
                        end else begin
                            idx_n = idx - IDX_W'(1);
                        end
                    end
                end
                default: begin
                    idx_n = idx;
                end
            endcase
        end
    end

    assign onehot = N_CH'(1) << idx;
    assign led    = (int'(idx) >= N_CH / 2);

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with N_CH=4, DIV_MAX=3; expectations are hand-computed.
module tb_led_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       load;
    logic       en;
    logic [3:0] onehot;
    logic [1:0] idx;
    logic       led;
    logic       tick;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    int pp_seq  [7] = '{1, 2, 3, 2, 1, 0, 1};
    int pp_wrap [7] = '{0, 0, 0, 1, 0, 0, 1};

    led_sequencer #(
        .N_CH   (4),
        .DIV_MAX(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .en    (en),
        .onehot(onehot),
        .idx   (idx),
        .led   (led),
        .tick  (tick),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s,
                                 input logic l, input logic e, input logic r);
        mode = m;
        sel  = s;
        load = l;
        en   = e;
        rst  = r;
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic stepClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(2'b01, 2'd0, 1'b0, 1'b1, 1'b1);
        stepClk(2);
        checkOutput("rst_idx", 32'(idx), 0);
        checkOutput("rst_onehot", 32'(onehot), 32'b0001);
        checkOutput("rst_led", 32'(led), 0);
        checkOutput("rst_tick", 32'(tick), 0);
        checkOutput("rst_wrap", 32'(wrap), 0);

        $display("[TB] direct mode");
        applyStimulus(2'b00, 2'd2, 1'b0, 1'b1, 1'b0);
        stepClk(1);
        checkOutput("direct2_onehot", 32'(onehot), 32'b0100);
        checkOutput("direct2_led", 32'(led), 1);
        checkOutput("direct2_tick", 32'(tick), 0);
        applyStimulus(2'b00, 2'd3, 1'b0, 1'b1, 1'b0);
        stepClk(1);
        checkOutput("direct3_onehot", 32'(onehot), 32'b1000);
        checkOutput("direct3_idx", 32'(idx), 3);
        stepClk(3);
        checkOutput("direct_no_tick", 32'(tick), 0);

        $display("[TB] step up");
        applyStimulus(2'b01, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClk(1);
        checkOutput("up_load_idx", 32'(idx), 0);
        applyStimulus(2'b01, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            stepClk(2);
            checkOutput("up_hold_idx", 32'(idx), 32'(k));
            checkOutput("up_hold_tick", 32'(tick), 0);
            stepClk(1);
            checkOutput("up_step_idx", 32'(idx), 32'((k + 1) % 4));
            checkOutput("up_step_tick", 32'(tick), 1);
            checkOutput("up_step_wrap", 32'(wrap), (k == 3) ? 1 : 0);
        end
        stepClk(1);
        applyStimulus(2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            stepClk(1);
            checkOutput("freeze_idx", 32'(idx), 0);
            checkOutput("freeze_tick", 32'(tick), 0);
        end
        applyStimulus(2'b01, 2'd0, 1'b0, 1'b1, 1'b0);
        stepClk(1);
        checkOutput("resume_hold_tick", 32'(tick), 0);
        stepClk(1);
        checkOutput("resume_idx", 32'(idx), 1);
        checkOutput("resume_tick", 32'(tick), 1);

        $display("[TB] ping pong");
        applyStimulus(2'b11, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClk(1);
        checkOutput("pp_load_idx", 32'(idx), 0);
        applyStimulus(2'b11, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            stepClk(3);
            checkOutput("pp_idx", 32'(idx), 32'(pp_seq[k]));
            checkOutput("pp_wrap", 32'(wrap), 32'(pp_wrap[k]));
        end

        $display("[TB] step down");
        applyStimulus(2'b10, 2'd0, 1'b0, 1'b1, 1'b0);
        stepClk(2);
        checkOutput("down_pre_idx", 32'(idx), 1);
        applyStimulus(2'b10, 2'd1, 1'b1, 1'b1, 1'b0);
        stepClk(1);
        checkOutput("down_load_idx", 32'(idx), 1);
        checkOutput("down_load_tick", 32'(tick), 0);
        checkOutput("down_load_wrap", 32'(wrap), 0);
        applyStimulus(2'b10, 2'd1, 1'b0, 1'b1, 1'b0);
        stepClk(3);
        checkOutput("down_idx0", 32'(idx), 0);
        checkOutput("down_wrap0", 32'(wrap), 0);
        stepClk(3);
        checkOutput("down_idx3", 32'(idx), 3);
        checkOutput("down_wrap3", 32'(wrap), 1);

        $display("[TB] mid-run reset");
        applyStimulus(2'b11, 2'd0, 1'b0, 1'b1, 1'b0);
        stepClk(3);
        checkOutput("pp2_idx", 32'(idx), 2);
        checkOutput("pp2_wrap", 32'(wrap), 1);
        stepClk(1);
        applyStimulus(2'b11, 2'd3, 1'b1, 1'b1, 1'b1);
        stepClk(1);
        checkOutput("midrst_idx", 32'(idx), 0);
        checkOutput("midrst_onehot", 32'(onehot), 32'b0001);
        checkOutput("midrst_tick", 32'(tick), 0);
        applyStimulus(2'b11, 2'd0, 1'b0, 1'b1, 1'b0);
        stepClk(2);
        checkOutput("post_rst_hold", 32'(idx), 0);
        stepClk(1);
        checkOutput("post_rst_idx", 32'(idx), 1);
        checkOutput("post_rst_wrap", 32'(wrap), 0);
        stepClk(3);
        checkOutput("post_rst_idx2", 32'(idx), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised successor to the 2-bit one-hot LED decoder: drives N_CH one-hot channel outputs plus a summary LED. It adds registered direct selection, prescaled up/down/ping-pong stepping, synchronous load and a wrap pulse. It sits between the board switch/button logic and the LED/segment pins, and replaces the fixed 4-output decoder on the lab board.

## Interface
- N_CH, 4: number of one-hot channels; legal range 2..16.
- DIV_MAX, 50_000_000: clock cycles per step tick; legal range 1..2^32-1.
- IDX_W, $clog2(N_CH): index width; derived, never overridden.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  operating mode: 00 DIRECT, 01 STEP_UP, 10 STEP_DOWN, 11 PING_PONG.
- sel  in  IDX_W  channel select; used in DIRECT mode and on load.
- load  in  1  synchronous load of sel into the index; valid in any mode.
- en  in  1  enables the prescaler in the stepping modes.
- onehot  out  N_CH  bit idx high, all others low.
- idx  out  IDX_W  current channel index.
- led  out  1  high when idx >= N_CH/2 (upper-half indicator).
- tick  out  1  one-cycle pulse when the prescaler expires.
- wrap  out  1  one-cycle pulse on a wrap or reversal.

## Operation
- State: idx register, dir register (0 = up, 1 = down), prescaler count cnt (width $clog2(DIV_MAX+1)).
- onehot and led are combinational decodes of the idx register. They add no latency.
- Priority per edge: rst > load > DIRECT update > tick step.
- rst: idx=0, dir=up, cnt=0, tick=0, wrap=0. Outputs after reset: onehot=...0001, led=0.
- load=1: idx<=sel, cnt<=0, dir<=up, no tick, no wrap. An out-of-range sel (N_CH not a power of 2) is clamped to N_CH-1.
- DIRECT:
  - idx<=sel every cycle; en is ignored.
  - cnt is held at 0. tick=0, wrap=0.
- Prescaler (stepping modes only):
  - With en=1, cnt increments. When cnt==DIV_MAX-1, the counter sets cnt<=0 and pulses tick.
  - With en=0, cnt holds.
- STEP_UP, on tick: idx<=idx+1. From N_CH-1 it goes to 0 and wrap pulses.
- STEP_DOWN, on tick: idx<=idx-1. From 0 it goes to N_CH-1 and wrap pulses.
- PING_PONG, on tick: step in direction dir.
  - Up at idx==N_CH-1: idx<=N_CH-2, dir<=down, wrap pulses.
  - Down at idx==0: idx<=1, dir<=up, wrap pulses.
- Mode change:
  - Takes effect on the next edge. idx and cnt are kept.
  - Entering PING_PONG keeps the current dir.
  - Entering STEP_UP or STEP_DOWN does not modify dir.
- Index arithmetic wraps modulo N_CH, not modulo 2^IDX_W.

## Timing
- sel to idx/onehot in DIRECT mode: 1 clk.
- load to idx: 1 clk.
- Tick period: exactly DIV_MAX enabled cycles. The first tick after reset or load comes DIV_MAX enabled cycles later.
- tick and wrap are registered and high for exactly 1 clk, aligned with the edge that updates idx.
- DIV_MAX=1 with en held high: tick every cycle and idx steps every cycle.
- load and tick in the same cycle: load wins, and the tick is suppressed.
- rst mid-sequence: the next edge gives the reset values regardless of the other inputs.

## Structure
- Package led_seq_pkg holds the mode constants MODE_DIRECT/STEP_UP/STEP_DOWN/PING_PONG and the 2-bit mode typedef.
- Sub-module tick_divider (parameter DIV_MAX; ports clk, rst, clr, en, tick) holds the prescaler. load drives its clr. It is reused elsewhere for debouncing.
- The index/direction FSM and decode live in led_sequencer.

## Test plan
All scenarios use N_CH=4 and DIV_MAX=3.
- Reset: assert rst for 2 clk with mode=01 and en=1. Required: idx=0, onehot=0001, led=0, tick=0, wrap=0.
- DIRECT: sel=2 → after 1 clk, onehot=0100 and led=1. Then sel=3 → onehot=1000. No tick at any point.
- STEP_UP: en=1 → idx sequence 0,1,2,3,0 at 3-clk spacing, with wrap pulsing on 3→0. Dropping en for 5 clk freezes idx and cnt.
- PING_PONG: from idx=0 → sequence 1,2,3,2,1,0,1, with wrap pulsing on the 3→2 and 0→1 transitions.
- STEP_DOWN: load with sel=1 while tick is due → idx=1 and no tick. Then stepping gives 0, then 3, with wrap pulsing on 0→3.
- Mid-run rst: rst during PING_PONG with dir=down → idx=0. After release, the next tick gives idx=1 (dir=up).
